// File: rtl/theta_cordic_feeder_if.sv
// Sample-stream inputs, CORDIC AXI4-Stream output and status flags of theta_cordic_feeder.
// The master view belongs to the feeder; the slave view belongs to the source and the CORDIC side.
interface theta_cordic_feeder_if;
    logic        thetaCosValid;
    logic [15:0] thetaCos;
    logic        thetaSinValid;
    logic [15:0] thetaSin;
    logic        mAxisTvalid;
    logic        mAxisTready;
    logic [31:0] mAxisTdata;
    logic        mAxisTlast;
    logic        overflow;
    logic        desync;

    modport master (
        input  thetaCosValid, thetaCos, thetaSinValid, thetaSin, mAxisTready,
        output mAxisTvalid, mAxisTdata, mAxisTlast, overflow, desync
    );
    modport slave (
        output thetaCosValid, thetaCos, thetaSinValid, thetaSin, mAxisTready,
        input  mAxisTvalid, mAxisTdata, mAxisTlast, overflow, desync
    );
endinterface

// File: rtl/theta_cordic_feeder.sv
// Re-pairs independently strobed cos/sin samples into {sin,cos} AXI4-Stream beats with per-line tlast.
// Build option THETA_FEED_LINE_SYNC_EN: leaving resync restarts the line (point counter zeroed).
module theta_sample_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        empty,
    output logic        full
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW:0]   wrPtr, rdPtr;
    logic [AW-1:0] wrAddr;

    // A push during flush lands in slot 0 so the resync pair survives the flush.
    assign wrAddr = flush ? '0 : wrPtr[AW-1:0];
    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign dout   = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push) mem[wrAddr] <= din;
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= push ? (AW+1)'(1) : '0;
        end else begin
            if (push) wrPtr <= wrPtr + (AW+1)'(1);
            if (pop)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end
endmodule

module theta_cordic_feeder #(
    parameter int POINTS_PER_LINE_P = 360,
    parameter int FIFO_DEPTH_P      = 16
) (
    input  logic                  clk_i,
    input  logic                  nrst_i,
    theta_cordic_feeder_if.master bus
);
    localparam int CW = (POINTS_PER_LINE_P > 1) ? $clog2(POINTS_PER_LINE_P) : 1;
    localparam logic [CW-1:0] LAST_PT = CW'(POINTS_PER_LINE_P - 1);

    typedef enum logic {ST_RUN, ST_RESYNC} state_t;

    state_t        state, stateNext;
    logic          tvalidQ, overflowQ;
    logic [31:0]   tdataQ;
    logic [CW-1:0] pointCnt;

    logic        cosEmpty, cosFull, sinEmpty, sinFull;
    logic [15:0] cosDout, sinDout, cosHead, sinHead;
    logic        cosAvail, sinAvail, canLoad, beat;
    logic        load, flush, cosPush, sinPush, dropEvt;

    // An empty FIFO is bypassed so a pair arriving together is presented on the next cycle.
    assign cosAvail = !cosEmpty || bus.thetaCosValid;
    assign sinAvail = !sinEmpty || bus.thetaSinValid;
    assign cosHead  = cosEmpty ? bus.thetaCos : cosDout;
    assign sinHead  = sinEmpty ? bus.thetaSin : sinDout;
    assign canLoad  = !tvalidQ || bus.mAxisTready;
    assign beat     = tvalidQ && bus.mAxisTready;

    theta_sample_fifo #(.DEPTH(FIFO_DEPTH_P)) uCosFifo (
        .clk_i(clk_i), .nrst_i(nrst_i), .flush(flush), .push(cosPush),
        .pop(load && !cosEmpty), .din(bus.thetaCos), .dout(cosDout),
        .empty(cosEmpty), .full(cosFull)
    );
    theta_sample_fifo #(.DEPTH(FIFO_DEPTH_P)) uSinFifo (
        .clk_i(clk_i), .nrst_i(nrst_i), .flush(flush), .push(sinPush),
        .pop(load && !sinEmpty), .din(bus.thetaSin), .dout(sinDout),
        .empty(sinEmpty), .full(sinFull)
    );

    always_comb begin
        stateNext = state;
        load      = 1'b0;
        flush     = 1'b0;
        cosPush   = 1'b0;
        sinPush   = 1'b0;
        dropEvt   = 1'b0;
        case (state)
            ST_RUN: begin
                load    = canLoad && cosAvail && sinAvail;
                // A bypassed sample is consumed directly; a full FIFO accepts only alongside a pop.
                cosPush = bus.thetaCosValid && !(load && cosEmpty) && (!cosFull || load);
                sinPush = bus.thetaSinValid && !(load && sinEmpty) && (!sinFull || load);
                dropEvt = (bus.thetaCosValid && cosFull && !load) ||
                          (bus.thetaSinValid && sinFull && !load);
                if (dropEvt) stateNext = ST_RESYNC;
            end
            ST_RESYNC: begin
                flush = 1'b1;
                if (bus.thetaCosValid && bus.thetaSinValid) begin
                    cosPush   = 1'b1;
                    sinPush   = 1'b1;
                    stateNext = ST_RUN;
                end
            end
            default: stateNext = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state     <= ST_RUN;
            overflowQ <= 1'b0;
        end else begin
            state <= stateNext;
            if (dropEvt) overflowQ <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            tvalidQ <= 1'b0;
            tdataQ  <= '0;
        end else if (load) begin
            tvalidQ <= 1'b1;
            tdataQ  <= {sinHead, cosHead};
        end else if (bus.mAxisTready) begin
            tvalidQ <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            pointCnt <= '0;
`ifdef THETA_FEED_LINE_SYNC_EN
        end else if (state == ST_RESYNC && stateNext == ST_RUN) begin
            pointCnt <= '0;
`endif
        end else if (beat) begin
            pointCnt <= (pointCnt == LAST_PT) ? '0 : pointCnt + CW'(1);
        end
    end

    assign bus.mAxisTvalid = tvalidQ;
    assign bus.mAxisTdata  = tdataQ;
    assign bus.mAxisTlast  = tvalidQ && (pointCnt == LAST_PT);
    assign bus.overflow    = overflowQ;
    assign bus.desync      = (state == ST_RESYNC);
endmodule

// File: tb/tb_theta_cordic_feeder.sv
// Directed bench for theta_cordic_feeder (P=4, DEPTH=16): pairing, latency, stall, overflow/resync, reset.
module tb_theta_cordic_feeder;
    logic clk = 1'b0;
    logic nrst;
    int   tests = 0;
    int   fails = 0;
    int   lineCnt = 0;

    theta_cordic_feeder_if bus();

    theta_cordic_feeder #(.POINTS_PER_LINE_P(4), .FIFO_DEPTH_P(16)) dut (
        .clk_i(clk), .nrst_i(nrst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cv, input logic [15:0] c, input logic sv, input logic [15:0] s);
        bus.thetaCosValid = cv;
        bus.thetaCos      = c;
        bus.thetaSinValid = sv;
        bus.thetaSin      = s;
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        bus.mAxisTready = 1'b0;
        #1;
        tests++; if (bus.mAxisTvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %b want 0", bus.mAxisTvalid); end
        tests++; if (bus.mAxisTdata !== 32'h0) begin fails++; $display("FAIL reset_tdata got %h want 0", bus.mAxisTdata); end
        tests++; if (bus.mAxisTlast !== 1'b0) begin fails++; $display("FAIL reset_tlast got %b want 0", bus.mAxisTlast); end
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        tests++; if (bus.desync !== 1'b0) begin fails++; $display("FAIL reset_desync got %b want 0", bus.desync); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        tick;
    endtask

    task automatic test_stream;
        logic [31:0] exp;
        bus.mAxisTready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(i < 8, 16'(i), i < 8, 16'(16'h100 + i));
            tick;
            if (i < 8) begin
                exp = 32'h0100_0000 + 32'(i) * 32'h0001_0001;
                tests++; if (bus.mAxisTvalid !== 1'b1 || bus.mAxisTdata !== exp) begin
                    fails++; $display("FAIL stream_beat%0d got v=%b d=%h want v=1 d=%h", i, bus.mAxisTvalid, bus.mAxisTdata, exp);
                end
                tests++; if (bus.mAxisTlast !== ((i % 4) == 3)) begin
                    fails++; $display("FAIL stream_tlast%0d got %b want %b", i, bus.mAxisTlast, (i % 4) == 3);
                end
            end else begin
                tests++; if (bus.mAxisTvalid !== 1'b0) begin fails++; $display("FAIL stream_idle got %b want 0", bus.mAxisTvalid); end
            end
        end
        lineCnt = 0;
    endtask

    task automatic test_latency;
        int k;
        logic expV;
        logic [31:0] exp;
        bus.mAxisTready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            k = c - 5;
            drive(c <= 2, 16'(16'h10 + c), c >= 5 && c <= 7, 16'(16'h20 + k));
            tick;
            expV = (c >= 5 && c <= 7);
            tests++; if (bus.mAxisTvalid !== expV) begin
                fails++; $display("FAIL latency_tvalid_c%0d got %b want %b", c, bus.mAxisTvalid, expV);
            end
            if (expV) begin
                exp = {16'(16'h20 + k), 16'(16'h10 + k)};
                tests++; if (bus.mAxisTdata !== exp || bus.mAxisTlast !== (lineCnt == 3)) begin
                    fails++; $display("FAIL latency_pair%0d got d=%h l=%b want d=%h l=%b", k, bus.mAxisTdata, bus.mAxisTlast, exp, lineCnt == 3);
                end
                lineCnt = (lineCnt + 1) % 4;
            end
        end
    endtask

    task automatic test_stall;
        bus.mAxisTready = 1'b0;
        drive(1'b1, 16'hAAAA, 1'b1, 16'h5555);
        tick;
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) begin
            tests++; if (bus.mAxisTvalid !== 1'b1 || bus.mAxisTdata !== 32'h5555_AAAA || bus.mAxisTlast !== (lineCnt == 3)) begin
                fails++; $display("FAIL stall_hold%0d got v=%b d=%h l=%b want v=1 d=5555aaaa l=%b", i, bus.mAxisTvalid, bus.mAxisTdata, bus.mAxisTlast, lineCnt == 3);
            end
            tick;
        end
        bus.mAxisTready = 1'b1;
        tick;
        lineCnt = (lineCnt + 1) % 4;
        tests++; if (bus.mAxisTvalid !== 1'b0) begin fails++; $display("FAIL stall_release got %b want 0", bus.mAxisTvalid); end
    endtask

    task automatic test_overflow;
        bus.mAxisTready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 16'(16'h300 + i), 1'b1, 16'(16'h400 + i));
            tick;
            if (i == 16) begin
                tests++; if (bus.overflow !== 1'b0 || bus.desync !== 1'b0) begin
                    fails++; $display("FAIL ovf_before got o=%b d=%b want 0 0", bus.overflow, bus.desync);
                end
            end
        end
        tests++; if (bus.overflow !== 1'b1 || bus.desync !== 1'b1) begin
            fails++; $display("FAIL ovf_drop got o=%b d=%b want 1 1", bus.overflow, bus.desync);
        end
        drive(1'b1, 16'hDEAD, 1'b0, 16'h0);
        tick;
        tests++; if (bus.desync !== 1'b1 || bus.mAxisTvalid !== 1'b1) begin
            fails++; $display("FAIL ovf_lone_cos got d=%b v=%b want 1 1", bus.desync, bus.mAxisTvalid);
        end
        drive(1'b1, 16'h7777, 1'b1, 16'h8888);
        tick;
`ifdef THETA_FEED_LINE_SYNC_EN
        lineCnt = 0;
`endif
        tests++; if (bus.desync !== 1'b0 || bus.overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_exit got d=%b o=%b want 0 1", bus.desync, bus.overflow);
        end
        tests++; if (bus.mAxisTdata !== 32'h0400_0300 || bus.mAxisTlast !== (lineCnt == 3)) begin
            fails++; $display("FAIL ovf_held got d=%h l=%b want 04000300 %b", bus.mAxisTdata, bus.mAxisTlast, lineCnt == 3);
        end
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        bus.mAxisTready = 1'b1;
        tick;
        lineCnt = (lineCnt + 1) % 4;
        tests++; if (bus.mAxisTvalid !== 1'b1 || bus.mAxisTdata !== 32'h8888_7777 || bus.mAxisTlast !== (lineCnt == 3)) begin
            fails++; $display("FAIL ovf_next got v=%b d=%h l=%b want 1 88887777 %b", bus.mAxisTvalid, bus.mAxisTdata, bus.mAxisTlast, lineCnt == 3);
        end
        tick;
        lineCnt = (lineCnt + 1) % 4;
        tests++; if (bus.mAxisTvalid !== 1'b0) begin fails++; $display("FAIL ovf_drain got %b want 0", bus.mAxisTvalid); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] exp;
        bus.mAxisTready = 1'b0;
        drive(1'b1, 16'h1111, 1'b1, 16'h2222);
        tick;
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        tests++; if (bus.mAxisTvalid !== 1'b1) begin fails++; $display("FAIL rst_mid_pre got %b want 1", bus.mAxisTvalid); end
        nrst = 1'b0;
        #1;
        tests++; if (bus.mAxisTvalid !== 1'b0 || bus.mAxisTdata !== 32'h0 || bus.mAxisTlast !== 1'b0 ||
                     bus.overflow !== 1'b0 || bus.desync !== 1'b0) begin
            fails++; $display("FAIL rst_mid_clear got v=%b d=%h l=%b o=%b s=%b want all 0",
                              bus.mAxisTvalid, bus.mAxisTdata, bus.mAxisTlast, bus.overflow, bus.desync);
        end
        @(negedge clk);
        nrst = 1'b1;
        tick;
        bus.mAxisTready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 16'(16'h500 + j), 1'b1, 16'(16'h600 + j));
            tick;
            exp = {16'(16'h600 + j), 16'(16'h500 + j)};
            tests++; if (bus.mAxisTvalid !== 1'b1 || bus.mAxisTdata !== exp || bus.mAxisTlast !== (j == 3)) begin
                fails++; $display("FAIL rst_line_beat%0d got v=%b d=%h l=%b want 1 %h %b", j, bus.mAxisTvalid, bus.mAxisTdata, bus.mAxisTlast, exp, j == 3);
            end
        end
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        tick;
    endtask

    initial begin
        test_reset;
        test_stream;
        test_latency;
        test_stall;
        test_overflow;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
